data_mem_resp: RTL
==================

# data_mem_resp

Data-memory responder for the RV32I core: the slave end of the `mem_read`/`mem_write`/`mem_size`/`is_signed` control bundle driven by the control unit. It holds word-organised RAM, performs byte/half/word stores with lane masking, and returns sign- or zero-extended load data. Loads use a 1-cycle synchronous-read FSM with a `mem_busy` stall output; misaligned or illegal-size accesses are blocked and reported. It sits between the ALU result (address) / rs2 (store data) and the writeback mux (`result_src = 2'b01`).

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; must be a power of two.
- `AW`, default 32: width of the address input.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `mem_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `is_signed`  in  1  1 = sign-extend load data, 0 = zero-extend.
- `addr`  in  AW  byte address (ALU result).
- `wdata`  in  32  store data; the low bytes are used for SB/SH.
- `rdata`  out  32  extended load data; valid only when `rdata_valid` is high.
- `rdata_valid`  out  1  load data present (RESP cycle).
- `mem_busy`  out  1  stall request to PC/pipeline (combinational).
- `misalign`  out  1  current request is misaligned or has illegal size (combinational).
- `fault_addr`  out  AW  address of the most recent blocked access (registered).

## Operation
- **Index.** Word index = `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- **Fault check.**
  - `misalign` = request active AND (size 11, OR half with `addr[0]`=1, OR word with `addr[1:0]`≠0).
  - A faulting access touches no RAM, raises no `mem_busy`, and never produces `rdata_valid`.
  - `fault_addr` captures `addr` on the clock edge that ends a faulting cycle in IDLE.
- **Priority.** If `mem_write` and `mem_read` are both high, the request is treated as a write; the read is dropped.
- **Store (IDLE only).** Committed at the rising edge ending the request cycle; no stall.
  - Byte: lane `addr[1:0]` ← `wdata[7:0]`.
  - Half: lanes {`addr[1]`,0} and {`addr[1]`,1} ← `wdata[15:0]`.
  - Word: all four lanes ← `wdata`.
  - Unaddressed lanes are unchanged.
- **FSM states.**
  - IDLE: an aligned read with no write moves to RESP. `addr[1:0]`, `mem_size` and `is_signed` are latched, and the RAM word is read synchronously.
  - RESP: `rdata_valid`=1. `rdata` is formed from the latched lane, size and sign over the RAM output. Any request present in RESP is ignored, because it is the same held load. RESP moves unconditionally to IDLE.
- **Extension.**
  - Byte: `rdata` = {24×ext, byte}.
  - Half: `rdata` = {16×ext, half}.
  - Word: `rdata` = RAM word unchanged.
  - ext = MSB of the selected data when `is_signed`=1, else 0.
- **`mem_busy`** = (state==IDLE AND aligned read AND no write).
- **Reset values.** state=IDLE, `rdata`=0, `rdata_valid`=0, `mem_busy`=0, `fault_addr`=0. RAM contents are not reset.
- **Reset mid-load.** An asserted `rst` aborts the load: no `rdata_valid`, FSM returns to IDLE.
- When `rdata_valid`=0, `rdata` is held at 0.

## Timing
- Load latency is 1 cycle. Request in cycle N gives `mem_busy`=1 in N, then `rdata_valid`=1 and `mem_busy`=0 in N+1. The load retires at the end of N+1.
- Back-to-back loads: the second load is accepted in N+2, the cycle after RESP. Sustained load throughput is 1 load per 2 cycles.
- Store in N followed by a load of the same word in N+1 returns the new data; no forwarding logic is needed.
- Store then store: 1 per cycle.
- `misalign` and `mem_busy` are combinational from the inputs in the same cycle. All other outputs are registered or depend only on registered state.

## Structure
- **Shared package.**
  - `MEM_B`=2'b00, `MEM_H`=2'b01, `MEM_W`=2'b10.
  - FSM state encoding: IDLE, RESP.
  - Helper constant for the index width, log2(`DEPTH_WORDS`).
- **Sub-module `dmem_bram`.** Single-port synchronous RAM with a 4-bit byte-write-enable and registered read output. This block generates the byte enables, runs the FSM, does the fault check and does the extension around it.

## Test plan
- SW `0xDEADBEEF` @`0x100`, then LW @`0x100` → `mem_busy`=1 for exactly 1 cycle; next cycle `rdata_valid`=1 and `rdata`=`0xDEADBEEF`.
- SB `0x80` @`0x102`, then LB → `0xFFFFFF80`, LBU → `0x00000080`; LW @`0x100` → `0xDE80BEEF`.
- SH `0x8001` @`0x106`, then LH → `0xFFFF8001`, LHU → `0x00008001`; lanes 0–1 of word `0x104` are unchanged.
- Misaligned accesses:
  - LW @`0x105` → `misalign`=1 in the same cycle, `mem_busy`=0, no `rdata_valid`, `fault_addr`=`0x105`.
  - SH @`0x103` → RAM unchanged.
  - `mem_size`=11 → fault.
- Assert `rst` in the cycle after a LW request → `rdata_valid` never asserts and all outputs return to reset values. Writing @`0x0`, then with `DEPTH_WORDS`=1024 reading @`0x1000`, returns the same word (wrap).
- Back-to-back LW/LW → second `rdata_valid` 2 cycles after the first. Held request in RESP is not re-accepted. SW followed by LW in the next cycle returns the new data.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Purpose: shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_resp_pkg;

    // mem_size encodings driven by the control unit (2'b11 is illegal)
    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int DEPTH_WORDS_DEF = 1024;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Word-index width for the default depth
    localparam int IDX_W_DEF = idx_w(DEPTH_WORDS_DEF);

    // Select the addressed byte/half out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_B:   return {{24{sgn & b[7]}}, b};
            MEM_H:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_dmem_bram.sv
// Purpose: single-port word RAM with per-byte write enables and registered read.
// Latency: read data appears the cycle after rd_en; writes commit on the same edge.
// Backpressure: none; accepts one access per cycle.
// Ports: clk; rd_en (capture mem[idx] into rdata); be (byte-lane write enables);
//        idx (word index); wdata (lane-aligned store data); rdata (registered read word).
module dmem_bram
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH = DEPTH_WORDS_DEF,
    parameter int IW    = IDX_W_DEF
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Contents are intentionally not reset; the read register is masked by the
    // consumer whenever it is not presenting a response.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Purpose: RV32I data-memory slave; byte/half/word stores, extended loads, fault blocking.
// Latency: stores commit at the end of the request cycle; loads respond one cycle later.
// Backpressure: mem_busy stalls the pipeline during an accepted load's request cycle.
// Ports: clk, rst (async active-high); mem_read/mem_write/mem_size/is_signed control;
//        addr (byte address), wdata (store data); rdata/rdata_valid (load response);
//        mem_busy, misalign (combinational); fault_addr (last blocked address).
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [1:0]    mem_size,
    input  logic          is_signed,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          rdata_valid,
    output logic          mem_busy,
    output logic          misalign,
    output logic [AW-1:0] fault_addr
);

    localparam int IW = idx_w(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic        req;
    logic        wr_ok;
    logic        rd_ok;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] ram_q;
    logic [1:0]  lat_lane;
    logic [1:0]  lat_size;
    logic        lat_sign;

    // ---------------- fault check and request qualification ----------------
    assign req = mem_read | mem_write;

    always_comb begin
        misalign = 1'b0;
        if (req) begin
            case (mem_size)
                MEM_B:   misalign = 1'b0;
                MEM_H:   misalign = addr[0];
                MEM_W:   misalign = (addr[1:0] != 2'b00);
                default: misalign = 1'b1;
            endcase
        end
    end

    // Write wins over a simultaneous read; requests seen during RESP belong to
    // the load already in flight and are ignored.
    assign wr_ok    = (state == ST_IDLE) && mem_write && !misalign;
    assign rd_ok    = (state == ST_IDLE) && mem_read && !mem_write && !misalign;
    assign mem_busy = rd_ok;

    // ---------------- store lane steering ----------------
    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        if (wr_ok) begin
            case (mem_size)
                MEM_B: begin
                    be    = 4'b0001 << addr[1:0];
                    wlane = {4{wdata[7:0]}};
                end
                MEM_H: begin
                    be    = addr[1] ? 4'b1100 : 4'b0011;
                    wlane = {2{wdata[15:0]}};
                end
                MEM_W: begin
                    be    = 4'b1111;
                    wlane = wdata;
                end
                default: be = 4'b0000;
            endcase
        end
    end

    dmem_bram #(
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_bram (
        .clk   (clk),
        .rd_en (rd_ok),
        .be    (be),
        .idx   (addr[IW+1:2]),
        .wdata (wlane),
        .rdata (ram_q)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rd_ok) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rdata_valid = 1'b0;
        rdata       = '0;
        if (state == ST_RESP) begin
            rdata_valid = 1'b1;
            rdata       = load_ext(ram_q, lat_lane, lat_size, lat_sign);
        end
    end

    // Lane/size/sign of the accepted load, needed one cycle later for extension
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_lane <= 2'b00;
            lat_size <= MEM_W;
            lat_sign <= 1'b0;
        end else if (rd_ok) begin
            lat_lane <= addr[1:0];
            lat_size <= mem_size;
            lat_sign <= is_signed;
        end
    end

    // Only faults raised from IDLE are recorded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_addr <= '0;
        end else if ((state == ST_IDLE) && misalign) begin
            fault_addr <= addr;
        end
    end

endmodule
